fp_two_sum_seq: RTL and testbench

//  Sequential error-free transform (Knuth TwoSum): decomposes a+b into S=fl(a+b) and E=(a+b)-S.

---
 rtl/fp_two_sum_seq_if.sv | 25 ++
 rtl/fp_two_sum_seq.sv | 219 +++++++++++++++++++++
 tb/tb_fp_two_sum_seq.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_two_sum_seq_if.sv
// Operand/result handshake bundle for the sequential TwoSum block.
// The master drives operands and result back-pressure; the slave (DUT) answers.
interface fp_two_sum_seq_if #(
  parameter int FP_WIDTH = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [FP_WIDTH-1:0] IN1;
  logic [FP_WIDTH-1:0] IN2;
  logic                out_valid;
  logic                out_ready;
  logic [FP_WIDTH-1:0] OUT_S;
  logic [FP_WIDTH-1:0] OUT_E;
  logic                OUT_EXACT;

  modport master (
    output in_valid, IN1, IN2, out_ready,
    input  in_ready, out_valid, OUT_S, OUT_E, OUT_EXACT
  );

  modport slave (
    input  in_valid, IN1, IN2, out_ready,
    output in_ready, out_valid, OUT_S, OUT_E, OUT_EXACT
  );
endinterface

// File: rtl/fp_two_sum_seq.sv
// Sequential Knuth TwoSum: S = fl(a+b), E = (a+b) - S, built from six passes
// through one shared round-to-nearest-even adder, one pass per cycle.
`ifndef ROUND_RTNE
`define ROUND_RTNE 0
`endif

module fp_two_sum_seq #(
  parameter int FP_WIDTH  = 32,
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic               clk,
  input  logic               rst,
  fp_two_sum_seq_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    C1   = 3'd1,
    C2   = 3'd2,
    C3   = 3'd3,
    C4   = 3'd4,
    C5   = 3'd5,
    C6   = 3'd6,
    DONE = 3'd7
  } state_t;

  state_t              state_q;
  logic [FP_WIDTH-1:0] a_q, b_q;       // latched operands
  logic [FP_WIDTH-1:0] s_q, bb_q, aa_q; // S, S-A, S-BB
  logic [FP_WIDTH-1:0] db_q, da_q;      // B-BB, A-AA
  logic [FP_WIDTH-1:0] e_q;             // DA+DB
  logic                in_ready_q;
  logic                out_valid_q;
  logic                exact_q;

  // Step operands for the shared adder, and the wrapped step result.
  logic [FP_WIDTH-1:0] op_x, op_y, y_eff, add_res, step_d;
  logic                op_sub;
  logic                x_zero, y_zero, cancel;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.OUT_S     = s_q;
  assign bus.OUT_E     = e_q;
  assign bus.OUT_EXACT = exact_q;

  // Pick this cycle's TwoSum step: which registers feed the adder, add or subtract.
  always_comb begin
    op_x   = a_q;
    op_y   = b_q;
    op_sub = 1'b0;
    unique case (state_q)
      C1:      begin op_x = a_q;  op_y = b_q;  op_sub = 1'b0; end
      C2:      begin op_x = s_q;  op_y = a_q;  op_sub = 1'b1; end
      C3:      begin op_x = s_q;  op_y = bb_q; op_sub = 1'b1; end
      C4:      begin op_x = b_q;  op_y = bb_q; op_sub = 1'b1; end
      C5:      begin op_x = a_q;  op_y = aa_q; op_sub = 1'b1; end
      C6:      begin op_x = da_q; op_y = db_q; op_sub = 1'b0; end
      default: begin op_x = a_q;  op_y = b_q;  op_sub = 1'b0; end
    endcase
  end

  // Subtraction is addition of the sign-flipped second operand.
  assign y_eff  = {op_y[FP_WIDTH-1] ^ op_sub, op_y[FP_WIDTH-2:0]};
  assign x_zero = (op_x[FP_WIDTH-2:MAN_WIDTH] == '0);
  assign y_zero = (y_eff[FP_WIDTH-2:MAN_WIDTH] == '0);
  assign cancel = (op_x[FP_WIDTH-2:0] == y_eff[FP_WIDTH-2:0]) &&
                  (op_x[FP_WIDTH-1] != y_eff[FP_WIDTH-1]);

  fp_add #(
    .EXP_WIDTH (EXP_WIDTH),
    .MAN_WIDTH (MAN_WIDTH),
    .ROUND_TYPE(`ROUND_RTNE)
  ) u_add (
    .x_i  (op_x),
    .y_i  (y_eff),
    .sum_o(add_res)
  );

  // The adder knows nothing about zero; zeros and exact cancellation are resolved here.
  always_comb begin
    step_d = add_res;
    if (y_zero)      step_d = op_x;
    else if (x_zero) step_d = y_eff;
    else if (cancel) step_d = '0;
  end

  // Control FSM plus step-result registers; all outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      bb_q        <= '0;
      aa_q        <= '0;
      db_q        <= '0;
      da_q        <= '0;
      e_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      exact_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.IN1;
            b_q        <= bus.IN2;
            in_ready_q <= 1'b0;
            state_q    <= C1;
          end
        end
        C1: begin s_q  <= step_d; state_q <= C2; end
        C2: begin bb_q <= step_d; state_q <= C3; end
        C3: begin aa_q <= step_d; state_q <= C4; end
        C4: begin db_q <= step_d; state_q <= C5; end
        C5: begin da_q <= step_d; state_q <= C6; end
        C6: begin
          e_q         <= step_d;
          exact_q     <= (step_d[FP_WIDTH-2:0] == '0);
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          // No bypass: in_ready only rises once back in IDLE.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// Combinational floating-point adder for normal, nonzero operands.
// Guard/round/sticky alignment, full leading-zero renormalisation, RTNE rounding.
module fp_add #(
  parameter int EXP_WIDTH  = 8,
  parameter int MAN_WIDTH  = 23,
  parameter int ROUND_TYPE = 0
) (
  input  logic [EXP_WIDTH+MAN_WIDTH:0] x_i,
  input  logic [EXP_WIDTH+MAN_WIDTH:0] y_i,
  output logic [EXP_WIDTH+MAN_WIDTH:0] sum_o
);

  localparam int FW = EXP_WIDTH + MAN_WIDTH + 1;
  localparam int XW = MAN_WIDTH + 4;   // hidden bit + fraction + guard/round/sticky
  localparam logic [EXP_WIDTH-1:0] XW_E = EXP_WIDTH'(XW);

  logic [FW-1:0]        big, sml;
  logic                 eff_sub;
  logic [EXP_WIDTH-1:0] exp_b, exp_s, diff, lz, exp_n;
  logic [XW-1:0]        sig_b, sig_s, al, mask, al_s, norm;
  logic                 sticky;
  logic [XW:0]          raw;
  logic                 rnd;
  logic                 unused_hidden;

  // Order by magnitude so the larger operand sets sign and exponent.
  always_comb begin
    if (y_i[FW-2:0] > x_i[FW-2:0]) begin
      big = y_i;
      sml = x_i;
    end else begin
      big = x_i;
      sml = y_i;
    end
  end

  assign eff_sub = big[FW-1] ^ sml[FW-1];
  assign exp_b   = big[FW-2:MAN_WIDTH];
  assign exp_s   = sml[FW-2:MAN_WIDTH];
  assign diff    = exp_b - exp_s;
  assign sig_b   = {1'b1, big[MAN_WIDTH-1:0], 3'b000};
  assign sig_s   = {1'b1, sml[MAN_WIDTH-1:0], 3'b000};

  // Align the smaller significand; everything shifted out collapses into the sticky LSB.
  always_comb begin
    mask = ~({XW{1'b1}} << diff);
    if (diff >= XW_E) begin
      al     = '0;
      sticky = 1'b1;
    end else begin
      al     = sig_s >> diff;
      sticky = |(sig_s & mask);
    end
    al_s = {al[XW-1:1], al[0] | sticky};
    raw  = eff_sub ? ({1'b0, sig_b} - {1'b0, al_s})
                   : ({1'b0, sig_b} + {1'b0, al_s});
  end

  // Renormalise: one right shift on carry-out, otherwise shift left past leading zeros.
  always_comb begin
    lz = '0;
    for (int i = 0; i < XW; i++) begin
      if (raw[i]) lz = EXP_WIDTH'(XW - 1 - i);
    end
    if (raw[XW]) begin
      norm  = {raw[XW:2], raw[1] | raw[0]};
      exp_n = exp_b + EXP_WIDTH'(1);
    end else begin
      norm  = raw[XW-1:0] << lz;
      exp_n = exp_b - lz;
    end
  end

  assign unused_hidden = norm[XW-1];

  // Round to nearest, ties to even; a mantissa carry ripples into the exponent.
  assign rnd   = (ROUND_TYPE == `ROUND_RTNE) ? (norm[2] & (norm[1] | norm[0] | norm[3])) : 1'b0;
  assign sum_o = {big[FW-1], {exp_n, norm[XW-2:3]} + (FW-1)'(rnd)};

endmodule

// File: tb/tb_fp_two_sum_seq.sv
// Scoreboard bench for fp_two_sum_seq: a driver issues operands and queues the
// expected S/E/EXACT; an independent monitor checks every delivered result.
module tb_fp_two_sum_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_two_sum_seq_if #(.FP_WIDTH(32)) bus ();

  fp_two_sum_seq #(.FP_WIDTH(32), .EXP_WIDTH(8), .MAN_WIDTH(23)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] s;
    logic [31:0] e;
    logic        x;
    int          hs;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   or_mode  = 0;   // 0: out_ready=1, 1: random, 2: held low
  int   last_hs  = -1;
  bit   b2b      = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // float32 <-> double, normal/zero values only
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [31:0] f;
    logic [10:0] e11;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'h0;
    e11 = d[62:52] - 11'd896;
    f = {d[63], e11[7:0], d[51:29]};
    if (d[28] && ((|d[27:0]) || d[29])) f[30:0] = f[30:0] + 31'd1;
    return f;
  endfunction

  // Reference: exact sum in double, S is its float rounding, E the exact remainder.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] s, output logic [31:0] e, output logic x);
    real sum;
    sum = f2r(a) + f2r(b);
    s   = r2f(sum);
    e   = r2f(sum - f2r(s));
    x   = (e[30:0] == 31'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present operands and wait for acceptance; caller runs just after a rising edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] es, input logic [31:0] ee, input logic ex,
                       input bit keep);
    int   t;
    exp_t en;
    t = 0;
    bus.in_valid = 1'b1;
    bus.IN1      = a;
    bus.IN2      = b;
    while (!bus.in_ready && t < 60) begin
      tick();
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout: got in_ready=0 expected 1 within 60 cycles");
      bus.in_valid = 1'b0;
      return;
    end
    en.s = es; en.e = ee; en.x = ex; en.hs = cyc + 1;
    if (b2b && last_hs >= 0) chk("b2b_spacing", en.hs - last_hs, 32'd8);
    last_hs = en.hs;
    sb.push_back(en);
    tick();
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic issue_rand(input bit keep);
    logic [31:0] a, b, s, e;
    logic        x;
    int          ea, eb, sel;
    ea  = $urandom_range(110, 145);
    eb  = ea + $urandom_range(0, 56) - 28;
    a   = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
    b   = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
    sel = $urandom_range(0, 9);
    if (sel == 0)      a = 32'h0;
    else if (sel == 1) b = 32'h0;
    else if (sel == 2) b = {~a[31], a[30:0]};
    else if (sel == 3) b = {~a[31], a[30:23], 23'($urandom)};
    model(a, b, s, e, x);
    issue(a, b, s, e, x, keep);
  endtask

  // Result-side back-pressure
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: latency, hold stability, no-bypass, and scoreboard compare on accept.
  logic [31:0] pv_s, pv_e;
  logic        pv_x;
  bit          pv_valid = 1'b0;
  always @(negedge clk) begin
    exp_t en;
    if (rst) begin
      pv_valid = 1'b0;
    end else begin
      if (bus.out_valid) begin
        chk("in_ready_in_done", 32'(bus.in_ready), 32'd0);
        if (!pv_valid) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got out_valid=1 expected no pending op");
          end else begin
            chk("latency", cyc, sb[0].hs + 6);
          end
        end else begin
          chk("hold_s", bus.OUT_S, pv_s);
          chk("hold_e", bus.OUT_E, pv_e);
          chk("hold_exact", 32'(bus.OUT_EXACT), 32'(pv_x));
        end
        if (bus.out_ready && sb.size() > 0) begin
          en = sb.pop_front();
          chk("out_s", bus.OUT_S, en.s);
          chk("out_e", bus.OUT_E, en.e);
          chk("out_exact", 32'(bus.OUT_EXACT), 32'(en.x));
        end
      end
      pv_valid = bus.out_valid;
      pv_s     = bus.OUT_S;
      pv_e     = bus.OUT_E;
      pv_x     = bus.OUT_EXACT;
    end
  end

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || bus.out_valid) && t < 400) begin
      tick();
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int t;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.IN1      = 32'h0;
    bus.IN2      = 32'h0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_s", bus.OUT_S, 32'h0);
    chk("rst_out_e", bus.OUT_E, 32'h0);
    chk("rst_out_exact", 32'(bus.OUT_EXACT), 32'd0);

    // Directed: small addend lost in S, recovered in E; carry; exact cancellation.
    issue(32'h3F800000, 32'h30800000, 32'h3F800000, 32'h30800000, 1'b0, 1'b0);
    issue(32'h3F800000, 32'h3F800000, 32'h40000000, 32'h00000000, 1'b1, 1'b0);
    issue(32'h3FC00000, 32'hBFC00000, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
    drain();

    // Consumer stalls 5 cycles in DONE while in_valid pulses are offered.
    @(negedge clk) or_mode = 2;
    tick();
    issue(32'h3F800000, 32'h3F800000, 32'h40000000, 32'h00000000, 1'b1, 1'b0);
    t = 0;
    while (!bus.out_valid && t < 20) begin
      tick();
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'(i % 2 == 0);
      bus.IN1      = 32'h41200000;
      bus.IN2      = 32'h40A00000;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("stall_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk) or_mode = 0;
    @(posedge clk);
    tick();
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);
    drain();

    // Reset pulse during C3 discards the op; a fresh op then completes normally.
    issue(32'h3F800000, 32'h30800000, 32'h3F800000, 32'h30800000, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    issue(32'h3F800000, 32'h30800000, 32'h3F800000, 32'h30800000, 1'b0, 1'b0);
    drain();

    // Randomized operands under random back-pressure.
    @(negedge clk) or_mode = 1;
    tick();
    for (int i = 0; i < 40; i++) issue_rand(1'b0);
    drain();

    // Zero bypass, then back-to-back issue with in_valid held high.
    @(negedge clk) or_mode = 0;
    tick();
    b2b     = 1'b1;
    last_hs = -1;
    issue(32'h00000000, 32'h40490FDB, 32'h40490FDB, 32'h00000000, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) issue_rand(i != 5);
    b2b = 1'b0;
    drain();

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
    $fatal(1);
  end

endmodule
